// File: rtl/mem_arb.sv
// Two-port round-robin arbiter in front of a single-ported synchronous memory.
// Define MEM_ARB_FIXED_PRIO_EN to give requester 0 absolute priority instead.
module mem_arb #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR     = 2'd1,
        RD     = 2'd2,
        RD_CAP = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                port_q, port_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;

    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                rvalid0_q, rvalid0_d;
    logic                rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_in_q, data_in_d;

    logic                pick1;

`ifndef MEM_ARB_FIXED_PRIO_EN
    // 1 = requester 1 won the most recent grant; reset value hands port 0 the first tie.
    logic                last_q, last_d;
`endif

    always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        pick1 = req1 & ~req0;
`else
        pick1 = req1 & (~req0 | ~last_q);
`endif
    end

    // Outputs are registered, so each state's strobe becomes visible one cycle after entry.
    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        read_d      = 1'b0;
        write_d     = 1'b0;
        addr_d      = addr_q;
        data_in_d   = data_in_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    port_d      = pick1;
                    cmd_addr_d  = pick1 ? addr1  : addr0;
                    cmd_wdata_d = pick1 ? wdata1 : wdata0;
                    gnt0_d      = ~pick1;
                    gnt1_d      = pick1;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    last_d      = pick1;
`endif
                    state_d     = (pick1 ? we1 : we0) ? WR : RD;
                end
            end
            WR: begin
                write_d   = 1'b1;
                addr_d    = cmd_addr_q;
                data_in_d = cmd_wdata_q;
                state_d   = IDLE;
            end
            RD: begin
                read_d  = 1'b1;
                addr_d  = cmd_addr_q;
                state_d = RD_CAP;
            end
            RD_CAP: begin
                // While read is still visible the memory is sampling it; data lands one edge later.
                if (!read_q) begin
                    if (port_q) begin
                        rdata1_d  = data_out;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = data_out;
                        rvalid0_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            port_q      <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            data_in_q   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            read_q      <= read_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            data_in_q   <= data_in_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign read    = read_q;
    assign write   = write_q;
    assign addr    = addr_q;
    assign data_in = data_in_q;

endmodule
